// File: rtl/lsu_bus_bridge_pkg.sv
// Shared definitions for the LSU-to-bus bridge: size encodings, FSM states,
// captured request metadata and the timeout counter width helper.
package lsu_bus_bridge_pkg;

   localparam logic [2:0] SIZE_B = 3'b001;
   localparam logic [2:0] SIZE_H = 3'b010;
   localparam logic [2:0] SIZE_W = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] size;
      logic       uns;
      logic [4:0] rd;
   } req_meta_t;

   // Counter must hold the value TIMEOUT_CYCLES itself; a disabled timeout still gets 1 bit.
   function automatic int tmo_cnt_w(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/lsu_bus_bridge_load_align.sv
// Load data aligner: selects the addressed byte/half/word from a raw bus word
// and sign- or zero-extends it to 32 bits.
module lsu_bus_bridge_load_align
   import lsu_bus_bridge_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  size,
   input  logic        uns,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[{addr_lo, 3'b000} +: 8];
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      if ((size & SIZE_W) != 3'b000)
         data = rdata;
      else if ((size & SIZE_H) != 3'b000)
         data = {{16{half_v[15] & ~uns}}, half_v};
      else
         data = {{24{byte_v[7] & ~uns}}, byte_v};
   end

endmodule

// File: rtl/lsu_bus_bridge.sv
// LSU request to valid/ack bus bridge with timeout and aligned load return.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word requests complete with error, never issued.
module lsu_bus_bridge
   import lsu_bus_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_sel,
   input  logic [2:0]  req_size,
   input  logic        req_unsigned,
   input  logic [4:0]  req_rd,
   output logic        bus_req,
   output logic [3:0]  bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic        resp_err,
   output logic        stall
);

   localparam int              CW        = tmo_cnt_w(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   TMO_LIMIT = CW'(TIMEOUT_CYCLES);
   localparam bit              TMO_EN    = (TIMEOUT_CYCLES != 0);

   state_t          state;
   req_meta_t       meta;
   logic [CW-1:0]   tmo_cnt;
   logic [3:0]      sel_q;
   logic            misalign;
   logic            skip_bus;
   logic            is_load;
   logic [31:0]     aligned;

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                     ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_ready = (state != ST_BUS);
   assign stall     = req_valid & ~req_ready;
   assign skip_bus  = (req_size == 3'b000) | misalign;
   assign is_load   = (bus_we == 4'b0000);

   lsu_bus_bridge_load_align u_align (
      .rdata   (bus_rdata),
      .addr_lo (bus_addr[1:0]),
      .size    (meta.size),
      .uns     (meta.uns),
      .data    (aligned)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         meta       <= '0;
         sel_q      <= '0;
         tmo_cnt    <= '0;
         bus_req    <= 1'b0;
         bus_we     <= '0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE, ST_RESP: begin
               if (req_valid) begin
                  bus_we    <= req_we;
                  bus_addr  <= req_addr;
                  bus_wdata <= req_wdata;
                  sel_q     <= req_sel;
                  meta      <= '{size: req_size, uns: req_unsigned, rd: req_rd};
                  tmo_cnt   <= '0;
                  if (skip_bus) begin
                     // Zero-size and rejected misaligned requests complete without a bus cycle.
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     resp_err   <= misalign;
                     resp_rd    <= (req_we == 4'b0000) ? req_rd : 5'd0;
                  end else begin
                     state   <= ST_BUS;
                     bus_req <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_BUS: begin
               if (bus_ack) begin
                  state      <= ST_RESP;
                  bus_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= is_load ? aligned : 32'd0;
                  resp_rd    <= is_load ? meta.rd : 5'd0;
               end else if (TMO_EN && (tmo_cnt == TMO_LIMIT)) begin
                  state      <= ST_RESP;
                  bus_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
                  resp_rd    <= is_load ? meta.rd : 5'd0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: directed vector table, randomized
// transactions against a reference model, and hand sequences for corner cases.
module tb_lsu_bus_bridge;
   import lsu_bus_bridge_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_sel;
   logic [2:0]  req_size;
   logic        req_unsigned;
   logic [4:0]  req_rd;
   logic        bus_req;
   logic [3:0]  bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_err;
   logic        stall;

   int checks = 0;
   int errors = 0;

   lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_rd(req_rd),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
      .resp_err(resp_err), .stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  size;
      bit          uns;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          ack_dly;
      logic [31:0] exp_data;
      bit          exp_err;
      logic [4:0]  exp_rd;
      int          exp_lat;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] size, input bit uns, input logic [4:0] rd,
                               input logic [31:0] rdata, input int ack_dly, input logic [31:0] exp_data,
                               input bit exp_err, input logic [4:0] exp_rd, input int exp_lat);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns; v.rd = rd;
      v.rdata = rdata; v.ack_dly = ack_dly; v.exp_data = exp_data; v.exp_err = exp_err;
      v.exp_rd = exp_rd; v.exp_lat = exp_lat;
      return v;
   endfunction

   // Reference load extraction: shift the addressed field down, mask, extend.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] sz, input bit u);
      int nb;
      int sh;
      logic [31:0] v;
      logic [31:0] mask;
      nb = (sz == SIZE_W) ? 4 : (sz == SIZE_H) ? 2 : 1;
      sh = (nb == 4) ? 0 : (nb == 2) ? 16 * int'(a[1]) : 8 * int'(a);
      v = w >> sh;
      if (nb == 4) return v;
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v = v & mask;
      if (!u && v[8 * nb - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] sz);
`ifdef LSU_MISALIGN_CHECK_EN
      return ((sz == SIZE_H) && (a % 2 != 0)) || ((sz == SIZE_W) && (a % 4 != 0));
`else
      return 1'b0;
`endif
   endfunction

   function automatic vec_t ref_vec(input vec_t v);
      vec_t r = v;
      bit is_load = (v.we == 4'b0000);
      r.exp_rd = is_load ? v.rd : 5'd0;
      if (v.size == 3'b000 || ref_misaligned(v.addr, v.size)) begin
         r.exp_lat = 1; r.exp_err = ref_misaligned(v.addr, v.size); r.exp_data = 0;
      end else if (v.ack_dly <= TO) begin
         r.exp_lat = 2 + v.ack_dly; r.exp_err = 0;
         r.exp_data = is_load ? ref_load(v.rdata, v.addr[1:0], v.size, v.uns) : 32'd0;
      end else begin
         r.exp_lat = 2 + TO; r.exp_err = 1; r.exp_data = 0;
      end
      return r;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int lat = 0;
      int bcyc = 0;
      bit got = 0;
      req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_sel = 4'hF;
      req_size = v.size; req_unsigned = v.uns; req_rd = v.rd; req_valid = 1'b1;
      #1;
      chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
      tick();
      lat = 1;
      req_valid = 1'b0;
      if (resp_valid) got = 1;
      while (!got && lat < 20) begin
         if (bus_req) begin
            if (bcyc == 0) begin
               chk({tag, ".bus_addr"}, bus_addr, v.addr);
               chk({tag, ".bus_wd"}, {bus_we, bus_wdata[27:0]}, {v.we, v.wdata[27:0]});
            end
            bus_ack = (bcyc == v.ack_dly);
            bus_rdata = bus_ack ? v.rdata : $urandom;
            if (bus_ack) chk({tag, ".addr_hold"}, bus_addr, v.addr);
            bcyc++;
         end
         tick();
         lat++;
         bus_ack = 1'b0;
         if (resp_valid) got = 1;
      end
      chk({tag, ".lat"}, lat, v.exp_lat);
      chk({tag, ".rdata"}, resp_rdata, v.exp_data);
      chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
      chk({tag, ".rd"}, {27'd0, resp_rd}, {27'd0, v.exp_rd});
      tick();
      chk({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int seen;
      resetn = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_sel = 0;
      req_size = 0; req_unsigned = 0; req_rd = 0; bus_ack = 0; bus_rdata = 0;

      vecs.push_back(mk(4'h0, 32'h1003, 0, SIZE_B, 0, 5'd7, 32'h80FF_1234, 2, 32'hFFFF_FF80, 0, 5'd7, 4));
      vecs.push_back(mk(4'h0, 32'h2002, 0, SIZE_H, 1, 5'd3, 32'hBEEF_0000, 0, 32'h0000_BEEF, 0, 5'd3, 2));
      vecs.push_back(mk(4'h0, 32'h2002, 0, SIZE_H, 0, 5'd3, 32'hBEEF_0000, 1, 32'hFFFF_BEEF, 0, 5'd3, 3));
      vecs.push_back(mk(4'hF, 32'h4000, 32'hDEAD_BEEF, SIZE_W, 0, 5'd9, 32'h5555_5555, 0, 32'h0, 0, 5'd0, 2));
      vecs.push_back(mk(4'h0, 32'h0020, 0, SIZE_W, 0, 5'd4, 32'h1111_1111, 99, 32'h0, 1, 5'd4, 6));
      vecs.push_back(mk(4'h0, 32'h0010, 0, SIZE_W, 0, 5'd6, 32'h1234_5678, 4, 32'h1234_5678, 0, 5'd6, 6));
      vecs.push_back(mk(4'h0, 32'h0040, 0, 3'b000, 0, 5'd8, 32'h0, 0, 32'h0, 0, 5'd8, 1));
      vecs.push_back(mk(4'h0, 32'h0051, 0, SIZE_B, 1, 5'd10, 32'h0000_AB00, 1, 32'h0000_00AB, 0, 5'd10, 3));
      vecs.push_back(mk(4'h3, 32'h0060, 32'h7777_7777, SIZE_H, 0, 5'd11, 32'h0, 99, 32'h0, 1, 5'd0, 6));
`ifdef LSU_MISALIGN_CHECK_EN
      vecs.push_back(mk(4'h0, 32'h3001, 0, SIZE_W, 0, 5'd12, 32'hCAFE_F00D, 0, 32'h0, 1, 5'd12, 1));
`else
      vecs.push_back(mk(4'h0, 32'h3001, 0, SIZE_W, 0, 5'd12, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 5'd12, 2));
`endif

      // Reset state
      tick(); tick();
      chk("rst.bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst.bus_addr", bus_addr, 32'd0);
      chk("rst.resp", {resp_valid, resp_err, resp_rd, resp_rdata[24:0]}, 32'd0);
      chk("rst.ready", {31'd0, req_ready}, 32'd1);
      resetn = 1'b1;
      tick();

      foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Randomized transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         vec_t v;
         int pick = $urandom_range(0, 9);
         v.size = (pick == 0) ? 3'b000 : (pick % 3 == 0) ? SIZE_B : (pick % 3 == 1) ? SIZE_H : SIZE_W;
         v.we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         v.addr = $urandom; v.wdata = $urandom; v.uns = 1'($urandom_range(0, 1));
         v.rd = 5'($urandom_range(0, 31)); v.rdata = $urandom; v.ack_dly = $urandom_range(0, 6);
         run_txn(ref_vec(v), $sformatf("rnd%0d", n));
      end

      // Back-to-back: second request captured in RESP
      req_we = 0; req_addr = 32'h100; req_size = SIZE_W; req_unsigned = 0; req_rd = 5'd1; req_valid = 1;
      tick();
      chk("b2b.stall_bus", {31'd0, stall}, 32'd1);
      req_addr = 32'h202; req_size = SIZE_B; req_unsigned = 1; req_rd = 5'd2;
      bus_ack = 1; bus_rdata = 32'h1122_3344;
      tick();
      bus_ack = 0;
      chk("b2b.resp1", {31'd0, resp_valid}, 32'd1);
      chk("b2b.data1", resp_rdata, 32'h1122_3344);
      chk("b2b.rd1", {27'd0, resp_rd}, 32'd1);
      chk("b2b.stall_resp", {31'd0, stall}, 32'd0);
      tick();
      chk("b2b.bus2", {31'd0, bus_req}, 32'd1);
      chk("b2b.addr2", bus_addr, 32'h202);
      chk("b2b.resp_drop", {31'd0, resp_valid}, 32'd0);
      req_valid = 0; bus_ack = 1; bus_rdata = 32'h00AB_0000;
      tick();
      bus_ack = 0;
      chk("b2b.data2", resp_rdata, 32'h0000_00AB);
      chk("b2b.rd2", {26'd0, resp_valid, resp_rd}, {26'd0, 1'b1, 5'd2});
      tick();

      // Ack while idle is ignored
      bus_ack = 1;
      tick(); tick();
      chk("idle_ack", {30'd0, resp_valid, bus_req}, 32'd0);
      bus_ack = 0;

      // Reset mid-BUS
      req_we = 0; req_addr = 32'h40; req_size = SIZE_W; req_rd = 5'd5; req_valid = 1;
      tick();
      req_valid = 0;
      chk("rstbus.req_hi", {31'd0, bus_req}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rstbus.async", {31'd0, bus_req}, 32'd0);
      tick();
      resetn = 1'b1;
      bus_ack = 1;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (resp_valid) seen++;
      end
      bus_ack = 0;
      chk("rstbus.no_resp", seen, 0);
      chk("rstbus.ready", {31'd0, req_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
